// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder slice stepped LSB-first over WIDTH cycles.
// Optional signed-overflow flag enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             h_c;
   logic             g1_c;
   logic             g2_c;
   logic             s_c;
   logic             c_next_c;
   logic             last_c;
   logic [WIDTH-1:0] sum_shift_c;

   // Full-adder slice built from two half-adders and an OR
   assign h_c         = a_sr[0] ^ b_sr[0];
   assign g1_c        = a_sr[0] & b_sr[0];
   assign s_c         = h_c ^ carry;
   assign g2_c        = h_c & carry;
   assign c_next_c    = g1_c | g2_c;
   assign last_c      = (cnt == CW'(WIDTH - 1));
   assign sum_shift_c = WIDTH'({s_c, sum_sr} >> 1);

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  sum_sr   <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shift_c;
               carry  <= c_next_c;
               if (last_c) begin
                  // Counter holds at WIDTH-1 so it never wraps
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  sum       <= sum_shift_c;
                  cout      <= c_next_c;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf       <= carry ^ c_next_c;
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, random adds and corner sequences.
module tb_serial_adder_ctrl;

   localparam int unsigned WIDTH = 16;
`ifdef SERIAL_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } vec_t;

   vec_t vecs[8];

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer add, signed overflow from operand/result signs
   task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mc,
                        output logic [WIDTH-1:0] ms, output logic mco, output logic mov);
      logic [WIDTH:0] t;
      t   = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
      ms  = t[WIDTH-1:0];
      mco = t[WIDTH];
      mov = OVF_EN && (ma[WIDTH-1] == mb[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b, input logic tc,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                          input int bp, input bit noise, input string tag);
      int  lat;
      bit  rdy_low;
      bit  stable;
      bit  busy_ok;
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      chk({tag, " ready before"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1; a = ta; b = tb_b; cin = tc;
      tick();
      in_valid = 1'b0;
      a = ~ta; b = ~tb_b; cin = ~tc;
      lat = 0; rdy_low = (in_ready == 1'b0); busy_ok = (busy == 1'b1);
      for (int k = 1; k <= int'(WIDTH) + 4; k++) begin
         if (noise && k < int'(WIDTH)) begin
            in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
         end
         tick();
         if (in_ready !== 1'b0) rdy_low = 1'b0;
         if (out_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      in_valid = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(WIDTH));
      chk({tag, " busy in run"}, 64'(busy_ok), 64'(1));
      chk({tag, " sum"}, 64'(sum), 64'(es));
      chk({tag, " cout"}, 64'(cout), 64'(ec));
      chk({tag, " ovf"}, 64'(ovf), 64'(eo));
      stable = 1'b1;
      for (int k = 0; k < bp; k++) begin
         tick();
         if (out_valid !== 1'b1 || sum !== es || cout !== ec || ovf !== eo || in_ready !== 1'b0)
            stable = 1'b0;
      end
      if (bp > 0) chk({tag, " backpressure hold"}, 64'(stable), 64'(1));
      chk({tag, " ready low until release"}, 64'(rdy_low), 64'(1));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " valid after take"}, 64'(out_valid), 64'(0));
      chk({tag, " ready after take"}, 64'(in_ready), 64'(1));
      chk({tag, " sum held idle"}, 64'(sum), 64'(es));
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb, rs;
      logic             rc, rco, rov;

      vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick(); tick();
      chk("reset in_ready", 64'(in_ready), 64'(1));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset sum", 64'(sum), 64'(0));
      chk("reset cout", 64'(cout), 64'(0));
      chk("reset ovf", 64'(ovf), 64'(0));

      // Reset and in_valid on the same edge: reset wins
      in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst+valid busy", 64'(busy), 64'(0));
      chk("rst+valid in_ready", 64'(in_ready), 64'(1));
      tick();
      chk("rst+valid no accept", 64'(busy), 64'(0));

      for (int i = 0; i < 8; i++)
         run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                 OVF_EN ? vecs[i].ovf : 1'b0, (i == 1) ? 5 : 0, 1'b0, $sformatf("vec%0d", i));

      // Operand noise during RUN must not disturb the accepted pair
      run_add(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1, 1'b1, "noise");

      // Abort mid-RUN after 7 bit edges
      in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      chk("abort busy before", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort in_ready", 64'(in_ready), 64'(1));
      chk("abort out_valid", 64'(out_valid), 64'(0));
      chk("abort busy", 64'(busy), 64'(0));
      chk("abort sum", 64'(sum), 64'(0));
      chk("abort cout", 64'(cout), 64'(0));
      run_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0, "after abort");

      for (int i = 0; i < 20; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom_range(1, 0));
         model(ra, rb, rc, rs, rco, rov);
         run_add(ra, rb, rc, rs, rco, rov, int'($urandom_range(3, 0)), 1'b0, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
